freq_gate_ctrl: RTL and testbench

Equal-precision (reciprocal) measurement core of the digital frequency meter. It sits directly upstream of the SPI result packer. It opens a measurement gate aligned to rising edges of channel A and counts four quantities: channel-A edges, base-clock cycles, channel-A high time, and the A→B phase delay. At the end of each gate it presents latched 32-bit results with a one-cycle `done_sig`, then starts the next gate.

---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/freq_gate_ctrl_if.sv | 19 +
 rtl/freq_gate_ctrl_edge_sync.sv | 33 +++
 rtl/freq_gate_ctrl.sv | 149 ++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and FSM encoding for the reciprocal frequency meter.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: CNT_W result width (also used by the SPI packer), default gate and
// timeout lengths, FSM state codes, and a small constant helper.
package freq_meter_pkg;

  localparam int CNT_W              = 32;
  localparam int GATE_CYCLES_DEF    = 50_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 100_000_000;

  typedef logic [2:0] fsm_state_t;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_OPEN  = 3'd1;
  localparam logic [2:0] ST_GATE       = 3'd2;
  localparam logic [2:0] ST_WAIT_CLOSE = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Result bus from the gate controller to the SPI result packer.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must capture on done_sig.
// Signals: fx_cnt, fbase_cnt, duty_cnt, time_cnt (CNT_W each), done_sig (1-cycle strobe).
// master = producer (freq_gate_ctrl), slave = consumer (packer).
interface freq_gate_ctrl_if #(
  parameter int CNT_W = freq_meter_pkg::CNT_W
);

  logic [CNT_W-1:0] fx_cnt;
  logic [CNT_W-1:0] fbase_cnt;
  logic [CNT_W-1:0] duty_cnt;
  logic [CNT_W-1:0] time_cnt;
  logic             done_sig;

  modport master (output fx_cnt, fbase_cnt, duty_cnt, time_cnt, done_sig);
  modport slave  (input  fx_cnt, fbase_cnt, duty_cnt, time_cnt, done_sig);

endinterface

// File: rtl/freq_gate_ctrl_edge_sync.sv
// 2-FF synchronizer followed by a registered rising-edge detector.
// Latency: pin edge to rise pulse = 3 clk; lvl changes in the same cycle as rise.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), din (async input), lvl (synchronized level),
// rise (1-cycle pulse on a synchronized 0->1 transition).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic s1;
  logic s2;

  // lvl is a registered copy of s2, so rise = s2 & ~lvl lines up with the
  // first cycle in which lvl reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      lvl  <= s2;
      rise <= s2 & ~lvl;
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Equal-precision frequency meter core: A-aligned gate, counts A edges, clk cycles, A high time, A->B delay.
// Latency: gate-close a_rise to done_sig/results = 1 clk; done_sig to next WAIT_OPEN = 2 clk.
// Backpressure: none; results hold until the next done_sig, consumer samples on the strobe.
// Ports: clk, rst_n (async active-low), meas_en (level run enable), sig_a / sig_b (async inputs),
// res (freq_gate_ctrl_if.master: fx_cnt, fbase_cnt, duty_cnt, time_cnt, done_sig).
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES    = GATE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = freq_meter_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic             sig_a,
  input  logic             sig_b,
  freq_gate_ctrl_if.master res
);

  localparam int TMR_W = $clog2(max_int(GATE_CYCLES, TIMEOUT_CYCLES) + 1);
  // The timer reads "cycles since gate open" in GATE, so leaving after the
  // G-1 value puts the gate-open + G cycle inside WAIT_CLOSE. An A rise
  // landing exactly there closes the gate, giving N = ceil(G/P).
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  logic a_lvl;
  logic a_rise;
  logic b_lvl_unused;
  logic b_rise;

  edge_sync u_sync_a (.clk(clk), .rst_n(rst_n), .din(sig_a), .lvl(a_lvl),        .rise(a_rise));
  edge_sync u_sync_b (.clk(clk), .rst_n(rst_n), .din(sig_b), .lvl(b_lvl_unused), .rise(b_rise));

  fsm_state_t       state;
  fsm_state_t       state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             armed;
  logic             armed_nxt;
  logic [CNT_W-1:0] fx_w, fbase_w, duty_w, time_w;
  logic [CNT_W-1:0] fx_nxt, fbase_nxt, duty_nxt, time_nxt;
  logic             counting;
  logic             tmo;
  logic             abort;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic is_active(input fsm_state_t s);
    return (s == ST_WAIT_OPEN) || (s == ST_GATE) || (s == ST_WAIT_CLOSE);
  endfunction

  assign counting = (state == ST_GATE) || (state == ST_WAIT_CLOSE);
  assign tmo      = ((state == ST_WAIT_OPEN) || (state == ST_WAIT_CLOSE)) && (tmr == TMO_LAST);
  // A qualifying A rise beats a coincident timeout.
  assign abort    = tmo && !a_rise;

  // Working counter next values include the current cycle, so the close
  // cycle's contribution is captured when the results are latched.
  assign fx_nxt    = sat_inc(fx_w,    counting && a_rise);
  assign fbase_nxt = sat_inc(fbase_w, counting);
  assign duty_nxt  = sat_inc(duty_w,  counting && a_lvl);
  assign time_nxt  = sat_inc(time_w,  counting && armed);

  // B rise wins, so a simultaneous A/B rise leaves armed at 0 (zero phase).
  always_comb begin
    armed_nxt = armed;
    if (a_rise) armed_nxt = 1'b1;
    if (b_rise) armed_nxt = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (meas_en) state_nxt = ST_WAIT_OPEN;
      ST_WAIT_OPEN:  if (a_rise) state_nxt = ST_GATE;
                     else if (tmo) state_nxt = ST_DONE;
      ST_GATE:       if (tmr == GATE_LAST) state_nxt = ST_WAIT_CLOSE;
      ST_WAIT_CLOSE: if (a_rise || tmo) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
    // Dropping the enable abandons the measurement; DONE always completes.
    if (!meas_en && (state != ST_DONE)) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      armed   <= 1'b0;
      fx_w    <= '0;
      fbase_w <= '0;
      duty_w  <= '0;
      time_w  <= '0;
    end else begin
      state <= state_nxt;

      // Timer restarts on every state change; the gate-open cycle counts as 1.
      if (state_nxt != state) tmr <= (state_nxt == ST_GATE) ? TMR_W'(1) : '0;
      else if (state != ST_IDLE) tmr <= tmr + TMR_W'(1);

      // Cleared at gate close and on any exit from the measuring states.
      armed <= (is_active(state) && is_active(state_nxt)) ? armed_nxt : 1'b0;

      if (state == ST_IDLE) begin
        fx_w    <= '0;
        fbase_w <= '0;
        duty_w  <= '0;
        time_w  <= '0;
      end else if (counting) begin
        fx_w    <= fx_nxt;
        fbase_w <= fbase_nxt;
        duty_w  <= duty_nxt;
        time_w  <= time_nxt;
      end
    end
  end

  // Results are loaded on the edge into DONE so they are valid while done_sig is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.fx_cnt    <= '0;
      res.fbase_cnt <= '0;
      res.duty_cnt  <= '0;
      res.time_cnt  <= '0;
      res.done_sig  <= 1'b0;
    end else begin
      res.done_sig <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        if (abort) begin
          res.fx_cnt    <= '0;
          res.fbase_cnt <= '0;
          res.duty_cnt  <= '0;
          res.time_cnt  <= '0;
        end else begin
          res.fx_cnt    <= fx_nxt;
          res.fbase_cnt <= fbase_nxt;
          res.duty_cnt  <= duty_nxt;
          res.time_cnt  <= time_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: a 32-bit instance and an 8-bit saturating instance share stimulus.
// A is a periodic square wave (period per_p, high per_h); B is the same wave delayed by lag.
module tb_freq_gate_ctrl;

  localparam int GATE = 1050;
  localparam int TMO  = 5000;

  logic clk = 1'b0;
  logic rst_n;
  logic meas_en;
  logic sig_a;
  logic sig_b;

  int n_vec  = 0;
  int n_miss = 0;

  bit gen_on = 1'b0;
  int per_p  = 100;
  int per_h  = 30;
  int lag    = 20;

  freq_gate_ctrl_if #(.CNT_W(32)) res_m ();
  freq_gate_ctrl_if #(.CNT_W(8))  res_s ();

  freq_gate_ctrl #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .meas_en(meas_en), .sig_a(sig_a), .sig_b(sig_b), .res(res_m)
  );

  freq_gate_ctrl #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .meas_en(meas_en), .sig_a(sig_a), .sig_b(sig_b), .res(res_s)
  );

  initial forever #5 clk = ~clk;

  // Pattern generator, updated on the falling edge.
  initial begin
    int ph;
    ph    = 0;
    sig_a = 1'b0;
    sig_b = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_on) begin
        sig_a = (ph < per_h);
        sig_b = (((ph + per_p - lag) % per_p) < per_h);
        ph    = (ph + 1) % per_p;
      end else begin
        sig_a = 1'b0;
        sig_b = 1'b0;
        ph    = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int fx, input int fb, input int du, input int ti);
    check({tag, "_fx"},    res_m.fx_cnt,    32'(fx));
    check({tag, "_fbase"}, res_m.fbase_cnt, 32'(fb));
    check({tag, "_duty"},  res_m.duty_cnt,  32'(du));
    check({tag, "_time"},  res_m.time_cnt,  32'(ti));
  endtask

  task automatic check_sat(input string tag, input int fx, input int fb, input int du, input int ti);
    check({tag, "_sat_fx"},    32'(res_s.fx_cnt),    32'(fx));
    check({tag, "_sat_fbase"}, 32'(res_s.fbase_cnt), 32'(fb));
    check({tag, "_sat_duty"},  32'(res_s.duty_cnt),  32'(du));
    check({tag, "_sat_time"},  32'(res_s.time_cnt),  32'(ti));
  endtask

  // Waits for done_sig on the main instance; cyc = falling edges elapsed.
  task automatic wait_done(input string tag, input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
      seen = res_m.done_sig;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_sat_done"},  32'(res_s.done_sig), 32'd1);
  endtask

  task automatic start_run(input int d);
    @(negedge clk);
    meas_en = 1'b0;
    gen_on  = 1'b0;
    repeat (10) @(negedge clk);
    lag     = d;
    gen_on  = 1'b1;
    meas_en = 1'b1;
  endtask

  initial begin
    int cyc;
    int dn;
    int k;

    rst_n   = 1'b0;
    meas_en = 1'b0;
    repeat (5) @(negedge clk);
    check_res("reset", 0, 0, 0, 0);
    check("reset_done", 32'(res_m.done_sig), 32'd0);
    check("reset_sat_fbase", 32'(res_s.fbase_cnt), 32'd0);
    rst_n = 1'b1;

    // P=100, H=30, D=20: N=ceil(1050/100)=11 -> 11, 1100, 330, 220.
    start_run(20);
    wait_done("s1", 3000, cyc);
    check_res("s1", 11, 1100, 330, 220);
    check_sat("s1", 11, 255, 255, 220);
    @(negedge clk);
    check("s1_done_width", 32'(res_m.done_sig), 32'd0);
    check_res("s1_hold", 11, 1100, 330, 220);

    // In phase: A and B rise together, no delay accumulates.
    start_run(0);
    wait_done("s2", 3000, cyc);
    check_res("s2", 11, 1100, 330, 0);
    check("s2_sat_time", 32'(res_s.time_cnt), 32'd0);

    // D=50 -> time 550; the 8-bit instance clamps three counters at 255.
    start_run(50);
    wait_done("s3", 3000, cyc);
    check_res("s3", 11, 1100, 330, 550);
    check_sat("s3", 11, 255, 255, 255);

    // A held low: one edge IDLE->WAIT_OPEN, then 5000 WAIT_OPEN cycles before DONE.
    @(negedge clk);
    meas_en = 1'b0;
    gen_on  = 1'b0;
    repeat (20) @(negedge clk);
    meas_en = 1'b1;
    wait_done("tmo", 6000, cyc);
    check("tmo_latency", 32'(cyc), 32'd5001);
    check_res("tmo", 0, 0, 0, 0);
    check("tmo_sat_fx", 32'(res_s.fx_cnt), 32'd0);

    // Enable dropped mid-gate for 10 cycles.
    start_run(20);
    wait_done("s4a", 3000, cyc);
    check_res("s4a", 11, 1100, 330, 220);
    repeat (300) @(negedge clk);
    meas_en = 1'b0;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_m.done_sig) dn++;
    end
    meas_en = 1'b1;
    check("drop_no_done", 32'(dn), 32'd0);
    check_res("drop_hold", 11, 1100, 330, 220);
    wait_done("s4b", 3000, cyc);
    // A fresh gate spans at least 1100 cycles after re-enable.
    check("s4b_restart", 32'(cyc >= 1100), 32'd1);
    check_res("s4b", 11, 1100, 330, 220);

    // Asynchronous reset in the middle of a gate.
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_res("rst_async", 0, 0, 0, 0);
    check("rst_async_sat_fbase", 32'(res_s.fbase_cnt), 32'd0);
    @(negedge clk);
    // Release while A is low so the cleared synchronizer sees a true rising edge.
    k = 0;
    while ((sig_a || sig_b) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b1;
    wait_done("s5", 3000, cyc);
    check_res("s5", 11, 1100, 330, 220);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
